// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and latency limit.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int LATENCY_MAX = 15;
endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering: byte enables, store-data shift, load extract/extend, error flag.
// DMEM_ALIGN_CHECK_EN: misaligned halfword/word is an error; otherwise low address bits are forced to zero.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic [1:0]  lo;
  logic [31:0] rsh;

  always_comb begin
    lo    = addr_lo_i;
    err_o = (size_i == SZ_RSVD);
`ifdef DMEM_ALIGN_CHECK_EN
    if (size_i == SZ_HALF && addr_lo_i[0])        err_o = 1'b1;
    if (size_i == SZ_WORD && addr_lo_i != 2'b00)  err_o = 1'b1;
`else
    if (size_i == SZ_HALF) lo[0] = 1'b0;
    if (size_i == SZ_WORD) lo    = 2'b00;
`endif
  end

  always_comb begin
    be_o = 4'b0000;
    case (size_i)
      SZ_BYTE: be_o = 4'b0001 << lo;
      SZ_HALF: be_o = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
    if (err_o) be_o = 4'b0000;
  end

  assign wdata_o = wdata_i << {lo, 3'b000};
  assign rsh     = rword_i >> {lo, 3'b000};

  always_comb begin
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & rsh[7]}}, rsh[7:0]};
      SZ_HALF: rdata_o = {{16{signed_i & rsh[15]}}, rsh[15:0]};
      SZ_WORD: rdata_o = rsh;
      default: rdata_o = 32'h0;
    endcase
    if (err_o) rdata_o = 32'h0;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, byte/half/word access to a word array.
// Optional DMEM_ALIGN_CHECK_EN turns misaligned accesses into errors instead of aligning them.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  data_mem_responder_if.slave   bus
);
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem [DEPTH];
  logic [3:0]        be;
  logic [31:0]       wdata_sh, rdata_ext, mask, merged;
  logic              err;
  logic              access;
  logic              unused_addr;

  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

  dmem_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .rword_i   (mem[addr_q[ADDR_W+1:2]]),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .rdata_o   (rdata_ext),
    .err_o     (err)
  );

  assign access = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged = (mem[addr_q[ADDR_W+1:2]] & ~mask) | (wdata_sh & mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        state_d = S_BUSY;
        cnt_d   = 4'(LATENCY - 1);
      end
      S_BUSY: if (cnt_q == 4'd0) state_d = S_RESP;
              else               cnt_d   = cnt_q - 4'd1;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.req_valid) begin
        write_q  <= bus.req_write;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr[ADDR_W+1:0];
        wdata_q  <= bus.req_wdata;
      end
      if (access) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rsp_rdata_q <= write_q ? 32'h0 : rdata_ext;
      end else if (state_q == S_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= 32'h0;
      end
    end
  end

  // Array is not reset; a reset during BUSY leaves state_q at IDLE so no write lands.
  always_ff @(posedge Clk) begin
    if (access && write_q && !err)
      mem[addr_q[ADDR_W+1:2]] <= merged;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
